lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of single_port_ram (data memory). Accepts byte-addressed CPU requests on a valid/ready interface and drives the RAM's word-wide addr/data/we, reading back q.
- Performs sign/zero extension on loads, and a read-modify-write sequence for byte and halfword stores.
- Returns one response per request.

Parameters:
- DATA_WIDTH, 32, RAM and CPU data width (fixed at 32 for lane logic)
- BYTE_ADDR_WIDTH, 32, CPU byte-address width
- MEM_ADDR_WIDTH, 10, RAM word-address width; mem_addr = req_addr[MEM_ADDR_WIDTH+1:2]

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller idle, request accepted when valid&ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  input  BYTE_ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-aligned
- resp_valid  output  1  response available
- resp_ready  input  1  response consumed when valid&ready
- resp_rdata  output  DATA_WIDTH  extended load data, 0 for stores/errors
- resp_err  output  1  request rejected, no memory access
- mem_addr  output  MEM_ADDR_WIDTH  to RAM addr
- mem_data  output  DATA_WIDTH  to RAM data
- mem_we  output  1  to RAM we
- mem_q  input  DATA_WIDTH  from RAM q; valid the cycle after mem_addr is presented

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Registered outputs, all reset to 0: mem_addr, mem_data, mem_we, resp_valid, resp_rdata, resp_err.
- req_ready is combinational: 1 only in IDLE and reset deasserted.
- Little-endian lanes: lane = req_addr[1:0]; lane 0 = bits 7:0. Halfword uses addr[1] (lane 0 or 2).
- FSM states: IDLE, WR, RD, CAP, RESP. Cycle 0 is the accept edge.
- Word store: IDLE→WR (mem_we=1, mem_data=wdata)→RESP. resp_valid at cycle 2.
- Load: IDLE→RD (mem_addr driven, mem_we=0)→CAP (mem_q sampled, lane extracted, extended into resp_rdata)→RESP. resp_valid at cycle 3.
- Byte/half store: IDLE→RD→CAP (merge wdata lanes into mem_q)→WR (mem_we=1, merged word)→RESP. resp_valid at cycle 4. Untouched lanes are preserved exactly.
- Size 11: IDLE→RESP with resp_err=1, resp_rdata=0. No RAM access. resp_valid at cycle 1.
- mem_we is 1 for exactly one cycle per store, only in WR.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready. On the handshake edge: resp_valid→0, state→IDLE. Next request is accepted no earlier than the following cycle (no back-to-back).
- Upper address bits above MEM_ADDR_WIDTH+1 are ignored (aliasing).
- Reset mid-operation: next edge returns to IDLE, clears all outputs, and discards the pending request/response. A write presented in the reset cycle itself may be committed by the RAM; no write occurs afterwards.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠00, is treated like size 11. resp_err=1, no RAM access, 1-cycle latency.
- Undefined: misaligned low bits are forced to alignment (half ignores addr[0], word ignores addr[1:0]); resp_err only for size 11.

Test Plan:
- Reset, then word store addr 0x08, wdata 0xFFFFFFFF → mem_we=1 for 1 cycle at mem_addr 2, resp_valid at cycle 2, resp_err=0. Word load 0x08 → resp_rdata 0xFFFFFFFF at cycle 3.
- Word store 0x0C=0x12345678; byte store addr 0x0D, wdata 0xAB → RAM word 3 = 0x1234AB78. Byte load 0x0D signed → 0xFFFFFFAB; unsigned → 0x000000AB.
- Word 0x10=0x98761234; half store addr 0x12, wdata 0xA0A0 → 0xA0A01234. Half load 0x12 signed → 0xFFFFA0A0. Half load 0x10 signed → 0x00001234.
- Load with resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0 throughout; request issued meanwhile is not accepted.
- size 11 → resp_err=1 at cycle 1, mem_we never asserted. With LSU_ALIGN_CHECK_EN, word store addr 0x15 → resp_err=1, RAM unchanged. Without it → word 5 written.
- Reset asserted in CAP of a byte store to 0x0C → no mem_we afterwards, word 3 unchanged, all outputs 0, req_ready=1 after reset releases.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-port word RAM: byte/half/word access,
// load extension, read-modify-write for narrow stores. Optional: LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_data,
    output logic                       mem_we,
    input  logic [DATA_WIDTH-1:0]      mem_q
);

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t state, state_nxt;

    logic                  op_we;
    logic                  op_uns;
    logic [1:0]            op_size;
    logic [1:0]            op_lane;
    logic [DATA_WIDTH-1:0] op_wdata;

    logic                      accept;
    logic                      req_err;
    logic [1:0]                req_lane;
    logic [4:0]                shamt;
    logic [DATA_WIDTH-1:0]     q_shift;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     lane_mask;
    logic [DATA_WIDTH-1:0]     merged;

    logic [MEM_ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0]     mem_data_nxt;
    logic                      mem_we_nxt;
    logic                      resp_valid_nxt;
    logic [DATA_WIDTH-1:0]     resp_rdata_nxt;
    logic                      resp_err_nxt;

    // Address bits above the RAM word range alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[BYTE_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
    assign req_err = (req_size == 2'b11)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign req_err = (req_size == 2'b11);
`endif

    // Misaligned low bits are dropped so halves land on lane 0/2 and words on lane 0.
    always_comb begin
        case (req_size)
            SZ_BYTE: req_lane = req_addr[1:0];
            SZ_HALF: req_lane = {req_addr[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
    end

    assign shamt   = {op_lane, 3'b000};
    assign q_shift = mem_q >> shamt;

    always_comb begin
        case (op_size)
            SZ_BYTE: load_data = {{(DATA_WIDTH-8){~op_uns & q_shift[7]}}, q_shift[7:0]};
            SZ_HALF: load_data = {{(DATA_WIDTH-16){~op_uns & q_shift[15]}}, q_shift[15:0]};
            default: load_data = mem_q;
        endcase
    end

    assign lane_mask = ((op_size == SZ_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << shamt;
    assign merged    = (mem_q & ~lane_mask) | ((op_wdata << shamt) & lane_mask);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_data   <= mem_data_nxt;
            mem_we     <= mem_we_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
        end
    end

    // NOTE: the captured request is pure datapath, only read after an accept has
    // loaded it, so it carries no reset and stays a plain enable flop.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_we    <= req_we;
            op_uns   <= req_unsigned;
            op_size  <= req_size;
            op_lane  <= req_lane;
            op_wdata <= req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                          state_nxt = RESP;
                    else if (req_we && req_size == SZ_WORD) state_nxt = WR;
                    else                                  state_nxt = RD;
                end
            end
            RD:   state_nxt = CAP;
            CAP:  state_nxt = op_we ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        mem_addr_nxt   = mem_addr;
        mem_data_nxt   = mem_data;
        mem_we_nxt     = 1'b0;
        resp_valid_nxt = resp_valid;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = resp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = '0;
                    end else begin
                        mem_addr_nxt = req_addr[MEM_ADDR_WIDTH+1:2];
                        if (req_we && req_size == SZ_WORD) begin
                            mem_we_nxt   = 1'b1;
                            mem_data_nxt = req_wdata;
                        end
                    end
                end
            end
            CAP: begin
                if (op_we) begin
                    mem_we_nxt   = 1'b1;
                    mem_data_nxt = merged;
                end else begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_rdata_nxt = load_data;
                end
            end
            WR: begin
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = 1'b0;
                resp_rdata_nxt = '0;
            end
            RESP: if (resp_ready) resp_valid_nxt = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, hand-written corner
// sequences, and random traffic against a byte-array reference model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data, mem_q;
    logic        mem_we;

    int n_vec = 0;
    int n_err = 0;

    lsu_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Word RAM behaving like single_port_ram: registered read, write on we.
    logic [31:0] ram [0:1023];
    int          we_cnt = 0;
    logic [9:0]  last_we_addr = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_data;
            we_cnt        = we_cnt + 1;
            last_we_addr  = mem_addr;
        end
        mem_q <= ram[mem_addr];
    end

    // Reference model: flat byte memory, little-endian.
    logic [7:0] ref_mem [0:4095];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_apply(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int wes);
        int base;
        int nbytes;
        logic [31:0] v;
        base   = int'(addr[11:0]);
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err    = (size == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'd1 && addr[0]) err = 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        base  = base - (base % nbytes);
        rdata = '0;
        wes   = 0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[base+i] = wdata[8*i +: 8];
            lat = (nbytes == 4) ? 2 : 4;
            wes = 1;
        end else begin
            v = '0;
            for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[base+i];
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'h1 << (8*nbytes)) - 32'h1);
            rdata = v;
            lat   = 3;
        end
    endtask

    // Issue one request, measure edges from accept to resp_valid, then handshake.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int wes);
        int  w0;
        bit  seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        w0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat  = 1;
        seen = resp_valid;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = resp_valid;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        wes = we_cnt - w0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, m_rd;
        logic        er, m_er;
        int          lat, wes, m_lat, m_wes, w0;
        logic [31:0] r_addr;

        for (int i = 0; i < 1024; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

        //           we    size   uns   addr          wdata          rdata         err   lat
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,         32'hFFFF_FFFF, 1'b0, 3});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'h1234_5678, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_000D, 32'h0000_00AB, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_000D, 32'h0,         32'hFFFF_FFAB, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_000D, 32'h0,         32'h0000_00AB, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0,         32'h1234_AB78, 1'b0, 3});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h9876_1234, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_A0A0, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_A0A0, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_1234, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hA0A0_1234, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0,         32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hABCD_1008, 32'h0,         32'hFFFF_FFFF, 1'b0, 3});
`ifdef LSU_ALIGN_CHECK_EN
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0015, 32'hDEAD_BEEF, 32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0,         32'h0,        1'b0, 3});
`else
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0015, 32'hDEAD_BEEF, 32'h0,        1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF, 1'b0, 3});
`endif

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[k]) begin
            ref_apply(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                      m_rd, m_er, m_lat, m_wes);
            run_txn(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                    rd, er, lat, wes);
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].rdata);
            check($sformatf("vec%0d_err", k), {31'b0, er}, {31'b0, vecs[k].err});
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
            check($sformatf("vec%0d_we_pulses", k), 32'(wes),
                  (vecs[k].we && !vecs[k].err) ? 32'd1 : 32'd0);
            if (vecs[k].we && !vecs[k].err)
                check($sformatf("vec%0d_we_addr", k), {22'b0, last_we_addr}, {22'b0, vecs[k].addr[11:2]});
        end
        check("ram_word3", ram[3], 32'h1234_AB78);
        check("ram_word4", ram[4], 32'hA0A0_1234);

        // Stalled response: outputs hold, a competing store is not accepted.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = '0;
        w0 = we_cnt;
        @(posedge clk); #1;
        req_we = 1'b1;
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("stall%0d_rdata", i), resp_rdata, 32'hFFFF_FFFF);
            check($sformatf("stall%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("stall_released", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_no_write", 32'(we_cnt - w0), 32'd0);
        check("stall_ram_word2", ram[2], 32'hFFFF_FFFF);

        // Reset while a byte store sits in CAP: nothing gets written.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'hC; req_wdata = 32'h55;
        w0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_resp_err", {31'b0, resp_err}, 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("midrst_mem_data", mem_data, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", {31'b0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(we_cnt - w0), 32'd0);
        check("midrst_ram_word3", ram[3], 32'h1234_AB78);

        // Random traffic over 16 words, upper address bits scrambled to exercise aliasing.
        for (int n = 0; n < 300; n++) begin
            logic       r_we, r_uns;
            logic [1:0] r_size;
            logic [31:0] r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr  = $urandom & 32'hFFFF_F03F;
            r_wdata = $urandom;
            ref_apply(r_we, r_size, r_uns, r_addr, r_wdata, m_rd, m_er, m_lat, m_wes);
            run_txn(r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat, wes);
            check($sformatf("rnd%0d_rdata", n), rd, m_rd);
            check($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, m_er});
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_we_pulses", n), 32'(wes), 32'(m_wes));
        end

        // Final sweep: RAM contents must equal the reference byte image.
        for (int w = 0; w < 16; w++) begin
            check($sformatf("final_word%0d", w), ram[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
